// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode, condition-code and NZCV flag definitions shared by the
//           ALU and its downstream stages.
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_LSL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd9;
    localparam logic [3:0] OP_SBC = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_MOV = 4'd12;
    localparam logic [3:0] OP_LDR = 4'd13;
    localparam logic [3:0] OP_STR = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_writeback_stage_cond_eval.sv
`default_nettype none
// ============================================================================
// cond_eval : combinational condition-code check against NZCV flags.
// Rev 1.0
// ============================================================================
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags_i[FLAG_N];
    assign w_z = flags_i[FLAG_Z];
    assign w_c = flags_i[FLAG_C];
    assign w_v = flags_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_AL: pass_o = 1'b1;
            COND_EQ: pass_o = w_z;
            COND_NE: pass_o = !w_z;
            COND_CS: pass_o = w_c;
            COND_CC: pass_o = !w_c;
            COND_MI: pass_o = w_n;
            COND_PL: pass_o = !w_n;
            COND_VS: pass_o = w_v;
            COND_VC: pass_o = !w_v;
            COND_HI: pass_o = w_c && !w_z;
            COND_LS: pass_o = !w_c || w_z;
            COND_GE: pass_o = (w_n == w_v);
            COND_LT: pass_o = (w_n != w_v);
            COND_GT: pass_o = !w_z && (w_n == w_v);
            COND_LE: pass_o = w_z || (w_n != w_v);
            default: pass_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// alu_writeback_stage : condition check, flag ownership, register write-back
//                       and LDR/STR memory handshake with timeout.
// Rev 1.0
// ============================================================================
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 4,
    parameter int TIMEOUT_CYC = 255
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_result_i,
    input  logic [3:0]        in_new_flag_i,
    input  logic [3:0]        in_opcode_i,
    input  logic [3:0]        in_cond_i,
    input  logic              in_s_i,
    input  logic [REG_AW-1:0] in_rd_i,
    input  logic [DATA_W-1:0] in_store_data_i,
    output logic [3:0]        flag_out_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_err_o
);

    localparam int                 CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [3:0]          flag_q;
    logic                rf_we_q;
    logic [REG_AW-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_err_q;
    logic [REG_AW-1:0]   ld_rd_q;
    logic                w_pass;
    logic                w_accept;
    logic                w_timeout;

    cond_eval u_cond_eval (
        .cond_i  (in_cond_i),
        .flags_i (flag_q),
        .pass_o  (w_pass)
    );

    assign in_ready_o = (state_q == ST_IDLE);
    assign w_accept   = in_valid_i && in_ready_o;
    assign cnt_d      = cnt_q + CNT_W'(1);
    // Abort on the edge where the wait count would reach the limit.
    assign w_timeout  = (cnt_d == C_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            flag_q      <= 4'b0000;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            ld_rd_q     <= '0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept && w_pass) begin
                        case (in_opcode_i)
                            OP_CMP: flag_q <= in_new_flag_i;
                            OP_LDR, OP_STR: begin
                                state_q    <= ST_MEM_REQ;
                                cnt_q      <= '0;
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= (in_opcode_i == OP_STR);
                                mem_addr_q <= in_result_i;
                                ld_rd_q    <= in_rd_i;
                                if (in_opcode_i == OP_STR) begin
                                    mem_wdata_q <= in_store_data_i;
                                end
                            end
                            OP_NOP: ;
                            default: begin
                                rf_we_q    <= 1'b1;
                                rf_waddr_q <= in_rd_i;
                                rf_wdata_q <= in_result_i;
                                if (in_s_i) begin
                                    flag_q <= in_new_flag_i;
                                end
                            end
                        endcase
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            mem_we_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else if (mem_rvalid_i) begin
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= ld_rd_q;
                            rf_wdata_q <= mem_rdata_i;
                            state_q    <= ST_IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_MEM_WAIT;
                        end
                    end else if (w_timeout) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= ld_rd_q;
                        rf_wdata_q <= mem_rdata_i;
                        state_q    <= ST_IDLE;
                    end else if (w_timeout) begin
                        mem_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign flag_out_o  = flag_q;
    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_err_o   = mem_err_q;

endmodule
`default_nettype wire
